alu_instr_sequencer: RTL and testbench

ALU_INSTR_SEQUENCER -- requirements
Module: alu_instr_sequencer

---
 rtl/alu_instr_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_alu_instr_sequencer.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_instr_sequencer.sv
// Fetch/execute control sequencer for a simple register-file datapath.
// Steps T0..T6 per instruction, with a bounded memory wait and a sticky fault state.
module alu_instr_sequencer #(
    parameter int WAIT_LIMIT = 15,
    parameter int COUNT_W    = 16
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic               stop,
    input  logic               mem_ready,
    input  logic [31:0]        ir_data,
    output logic [15:0]        reg_in,
    output logic [15:0]        reg_out,
    output logic               PC_in,
    output logic               PC_out,
    output logic               IncPC,
    output logic               IR_in,
    output logic               MAR_in,
    output logic               MDR_in,
    output logic               MDR_out,
    output logic               Read,
    output logic               Y_in,
    output logic               Z_in,
    output logic               Zlow_out,
    output logic               Zhigh_out,
    output logic               HI_in,
    output logic               LO_in,
    output logic [4:0]         alu_instruction,
    output logic               busy,
    output logic               done,
    output logic               fault,
    output logic [COUNT_W-1:0] instr_count
);

    localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

    typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, FAULT} state_t;

    state_t            state;
    logic              run;
    logic              run_nx;
    logic [WAIT_W-1:0] wait_cnt;
    logic              final_step;

    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       is_alu3, is_muldiv, is_negnot, op_valid;
    logic       unused_ir;

    assign op        = ir_data[31:27];
    assign ra        = ir_data[26:23];
    assign rb        = ir_data[22:19];
    assign rc        = ir_data[18:15];
    assign unused_ir = ^ir_data[14:0];

    assign is_alu3   = (op >= 5'd3) && (op <= 5'd11);
    assign is_muldiv = (op == 5'd15) || (op == 5'd16);
    assign is_negnot = (op == 5'd17) || (op == 5'd18);
    assign op_valid  = is_alu3 || is_muldiv || is_negnot;

    // stop wins over start; the latest request decides whether to keep fetching
    assign run_nx = !stop && (start || run);

    assign final_step = ((state == T4) && is_negnot) ||
                        ((state == T5) && !is_muldiv) ||
                        (state == T6);

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= IDLE;
            run         <= 1'b0;
            wait_cnt    <= '0;
            instr_count <= '0;
        end else begin
            if (state != FAULT)
                run <= run_nx;
            case (state)
                IDLE:    if (run_nx) state <= T0;
                T0: begin
                    wait_cnt <= '0;
                    state    <= T1;
                end
                T1: begin
                    if (mem_ready)
                        state <= T2;
                    else if (wait_cnt == WAIT_LAST)
                        state <= FAULT;
                    else
                        wait_cnt <= wait_cnt + 1'b1;
                end
                T2:      state <= T3;
                T3:      state <= op_valid ? T4 : FAULT;
                T4:      state <= T5;
                T5:      state <= T6;
                T6:      state <= IDLE;
                FAULT:   state <= FAULT;
                default: state <= IDLE;
            endcase
            // The last step of every instruction overrides the walk above
            if (final_step) begin
                state       <= run_nx ? T0 : IDLE;
                instr_count <= instr_count + 1'b1;
            end
        end
    end

    always_comb begin
        reg_in          = '0;
        reg_out         = '0;
        PC_in           = 1'b0;
        PC_out          = 1'b0;
        IncPC           = 1'b0;
        IR_in           = 1'b0;
        MAR_in          = 1'b0;
        MDR_in          = 1'b0;
        MDR_out         = 1'b0;
        Read            = 1'b0;
        Y_in            = 1'b0;
        Z_in            = 1'b0;
        Zlow_out        = 1'b0;
        Zhigh_out       = 1'b0;
        HI_in           = 1'b0;
        LO_in           = 1'b0;
        alu_instruction = '0;
        case (state)
            T0: begin
                PC_out          = 1'b1;
                MAR_in          = 1'b1;
                IncPC           = 1'b1;
                Z_in            = 1'b1;
                alu_instruction = 5'b00011;
            end
            T1: begin
                Zlow_out = 1'b1;
                Read     = 1'b1;
                MDR_in   = 1'b1;
                PC_in    = (wait_cnt == '0);
            end
            T2: begin
                MDR_out = 1'b1;
                IR_in   = 1'b1;
            end
            T3: begin
                if (is_alu3) begin
                    reg_out = 16'h0001 << rb;
                    Y_in    = 1'b1;
                end else if (is_muldiv) begin
                    reg_out = 16'h0001 << ra;
                    Y_in    = 1'b1;
                end else if (is_negnot) begin
                    reg_out         = 16'h0001 << rb;
                    alu_instruction = op;
                    Z_in            = 1'b1;
                end
            end
            T4: begin
                if (is_negnot) begin
                    Zlow_out = 1'b1;
                    reg_in   = 16'h0001 << ra;
                end else begin
                    reg_out         = 16'h0001 << (is_muldiv ? rb : rc);
                    alu_instruction = op;
                    Z_in            = 1'b1;
                end
            end
            T5: begin
                Zlow_out = 1'b1;
                if (is_muldiv)
                    LO_in = 1'b1;
                else
                    reg_in = 16'h0001 << ra;
            end
            T6: begin
                Zhigh_out = 1'b1;
                HI_in     = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy  = (state != IDLE) && (state != FAULT);
    assign fault = (state == FAULT);
    assign done  = final_step;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Scoreboard bench for alu_instr_sequencer: per-cycle expected outputs are queued
// from a table of the step decodes and compared one cycle at a time.
module tb_alu_instr_sequencer;

    logic        clk = 1'b0;
    logic        clr, start, stop, mem_ready;
    logic [31:0] ir_data;
    logic [15:0] reg_in, reg_out;
    logic        PC_in, PC_out, IncPC, IR_in, MAR_in, MDR_in, MDR_out, Read;
    logic        Y_in, Z_in, Zlow_out, Zhigh_out, HI_in, LO_in;
    logic [4:0]  alu_instruction;
    logic        busy, done, fault;
    logic [3:0]  instr_count;

    localparam int S_IDLE = 0, S_T0 = 1, S_T1 = 2, S_T2 = 3, S_T3 = 4,
                   S_T4 = 5, S_T5 = 6, S_T6 = 7, S_FAULT = 8;

    typedef struct {
        int          st;
        logic [53:0] vec;
        logic [3:0]  cnt;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] model_cnt;
    int         n_checks = 0;
    int         n_fail   = 0;

    alu_instr_sequencer #(.WAIT_LIMIT(15), .COUNT_W(4)) dut (
        .clk(clk), .clr(clr), .start(start), .stop(stop), .mem_ready(mem_ready),
        .ir_data(ir_data), .reg_in(reg_in), .reg_out(reg_out), .PC_in(PC_in),
        .PC_out(PC_out), .IncPC(IncPC), .IR_in(IR_in), .MAR_in(MAR_in),
        .MDR_in(MDR_in), .MDR_out(MDR_out), .Read(Read), .Y_in(Y_in), .Z_in(Z_in),
        .Zlow_out(Zlow_out), .Zhigh_out(Zhigh_out), .HI_in(HI_in), .LO_in(LO_in),
        .alu_instruction(alu_instruction), .busy(busy), .done(done), .fault(fault),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    function automatic logic [53:0] observed();
        return {reg_in, reg_out, PC_in, PC_out, IncPC, IR_in, MAR_in, MDR_in, MDR_out,
                Read, Y_in, Z_in, Zlow_out, Zhigh_out, HI_in, LO_in, alu_instruction,
                busy, done, fault};
    endfunction

    // Expected outputs for one step, taken straight from the step table
    function automatic logic [53:0] ev(input int st, input logic [31:0] ir, input bit first);
        logic [4:0]  op, alu;
        logic [3:0]  ra, rb, rc;
        logic [15:0] ri, ro;
        logic pci, pco, inc, iri, mari, mdri, mdro, rd, yi, zi, zlo, zho, hii, loi;
        logic bz, dn, ft;
        bit three, md, nn;
        op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
        three = (op >= 5'd3) && (op <= 5'd11);
        md    = (op == 5'd15) || (op == 5'd16);
        nn    = (op == 5'd17) || (op == 5'd18);
        ri = '0; ro = '0; alu = '0;
        {pci, pco, inc, iri, mari, mdri, mdro, rd, yi, zi, zlo, zho, hii, loi} = '0;
        bz = (st >= S_T0) && (st <= S_T6);
        dn = 1'b0;
        ft = (st == S_FAULT);
        case (st)
            S_T0: begin pco = 1; mari = 1; inc = 1; zi = 1; alu = 5'b00011; end
            S_T1: begin zlo = 1; rd = 1; mdri = 1; pci = first; end
            S_T2: begin mdro = 1; iri = 1; end
            S_T3: begin
                if (three)   begin ro = 16'h0001 << rb; yi = 1; end
                else if (md) begin ro = 16'h0001 << ra; yi = 1; end
                else if (nn) begin ro = 16'h0001 << rb; alu = op; zi = 1; end
            end
            S_T4: begin
                if (three)   begin ro = 16'h0001 << rc; alu = op; zi = 1; end
                else if (md) begin ro = 16'h0001 << rb; alu = op; zi = 1; end
                else if (nn) begin zlo = 1; ri = 16'h0001 << ra; dn = 1; end
            end
            S_T5: begin
                zlo = 1;
                if (md) loi = 1;
                else begin ri = 16'h0001 << ra; dn = 1; end
            end
            S_T6: begin zho = 1; hii = 1; dn = 1; end
            default: ;
        endcase
        return {ri, ro, pci, pco, inc, iri, mari, mdri, mdro, rd, yi, zi, zlo, zho,
                hii, loi, alu, bz, dn, ft};
    endfunction

    task automatic push(input int st, input logic [31:0] ir, input bit first);
        exp_t e;
        e.st  = st;
        e.vec = ev(st, ir, first);
        e.cnt = model_cnt;
        sb.push_back(e);
        if (e.vec[1]) model_cnt = model_cnt + 4'd1;
    endtask

    task automatic push_instr(input logic [31:0] ir, input int n_low);
        logic [4:0] op;
        op = ir[31:27];
        push(S_T0, ir, 0);
        push(S_T1, ir, 1);
        repeat (n_low) push(S_T1, ir, 0);
        push(S_T2, ir, 0);
        push(S_T3, ir, 0);
        if ((op >= 5'd3) && (op <= 5'd11)) begin
            push(S_T4, ir, 0); push(S_T5, ir, 0);
        end else if ((op == 5'd15) || (op == 5'd16)) begin
            push(S_T4, ir, 0); push(S_T5, ir, 0); push(S_T6, ir, 0);
        end else if ((op == 5'd17) || (op == 5'd18)) begin
            push(S_T4, ir, 0);
        end
    endtask

    task automatic applyStimulus(input logic c, input logic s, input logic p, input logic m);
        clr = c; start = s; stop = p; mem_ready = m;
    endtask

    task automatic test_reset();
        exp_t e;
        int i = 0;
        ir_data = 32'h0;
        model_cnt = 4'd0;
        push(S_IDLE, ir_data, 0);
        push(S_IDLE, ir_data, 0);
        while (sb.size() > 0) begin
            applyStimulus(i == 0, i == 0, 1'b0, 1'b1);
            @(posedge clk); #1;
            e = sb.pop_front(); n_checks++;
            if ({observed(), instr_count} !== {e.vec, e.cnt}) begin
                n_fail++;
                $display("[TB] FAIL reset step %0d st=%0d: got %h/%0d expected %h/%0d", i, e.st, observed(), instr_count, e.vec, e.cnt);
            end
            i++;
        end
    endtask

    task automatic test_rol();
        exp_t e;
        int i = 0;
        ir_data = 32'h5B32_0000;
        push_instr(ir_data, 0);
        push(S_IDLE, ir_data, 0);
        while (sb.size() > 0) begin
            applyStimulus(1'b0, i == 0, i == 2, 1'b1);
            @(posedge clk); #1;
            e = sb.pop_front(); n_checks++;
            if ({observed(), instr_count} !== {e.vec, e.cnt}) begin
                n_fail++;
                $display("[TB] FAIL rol step %0d st=%0d: got %h/%0d expected %h/%0d", i, e.st, observed(), instr_count, e.vec, e.cnt);
            end
            i++;
        end
        n_checks++;
        if (instr_count !== 4'd1) begin
            n_fail++;
            $display("[TB] FAIL rol_count: got %0d expected 1", instr_count);
        end
    endtask

    task automatic test_mem_wait(input int n_low);
        exp_t e;
        int i = 0;
        ir_data = {5'b10001, 4'd1, 4'd5, 4'd0, 15'd0};
        push_instr(ir_data, n_low);
        push(S_IDLE, ir_data, 0);
        while (sb.size() > 0) begin
            applyStimulus(1'b0, i == 0, i == 2, !((i >= 2) && (i < 2 + n_low)));
            @(posedge clk); #1;
            e = sb.pop_front(); n_checks++;
            if ({observed(), instr_count} !== {e.vec, e.cnt}) begin
                n_fail++;
                $display("[TB] FAIL mem_wait%0d step %0d st=%0d: got %h/%0d expected %h/%0d", n_low, i, e.st, observed(), instr_count, e.vec, e.cnt);
            end
            i++;
        end
    endtask

    task automatic test_wait_fault();
        exp_t e;
        int i = 0;
        ir_data = {5'b10001, 4'd1, 4'd5, 4'd0, 15'd0};
        push(S_T0, ir_data, 0);
        push(S_T1, ir_data, 1);
        repeat (14) push(S_T1, ir_data, 0);
        push(S_FAULT, ir_data, 0);
        push(S_FAULT, ir_data, 0);
        model_cnt = 4'd0;
        push(S_IDLE, ir_data, 0);
        push(S_IDLE, ir_data, 0);
        while (sb.size() > 0) begin
            applyStimulus(i == 18, (i == 0) || (i == 17), 1'b0, 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front(); n_checks++;
            if ({observed(), instr_count} !== {e.vec, e.cnt}) begin
                n_fail++;
                $display("[TB] FAIL wait_fault step %0d st=%0d: got %h/%0d expected %h/%0d", i, e.st, observed(), instr_count, e.vec, e.cnt);
            end
            i++;
        end
    endtask

    task automatic test_mul();
        exp_t e;
        int i = 0;
        ir_data = {5'b01111, 4'd2, 4'd3, 4'd0, 15'd0};
        push_instr(ir_data, 0);
        push(S_IDLE, ir_data, 0);
        while (sb.size() > 0) begin
            applyStimulus(1'b0, i == 0, i == 2, 1'b1);
            @(posedge clk); #1;
            e = sb.pop_front(); n_checks++;
            if ({observed(), instr_count} !== {e.vec, e.cnt}) begin
                n_fail++;
                $display("[TB] FAIL mul step %0d st=%0d: got %h/%0d expected %h/%0d", i, e.st, observed(), instr_count, e.vec, e.cnt);
            end
            i++;
        end
    endtask

    task automatic test_bad_op();
        exp_t e;
        int i = 0;
        ir_data = {5'b11111, 27'd0};
        push_instr(ir_data, 0);
        push(S_FAULT, ir_data, 0);
        push(S_FAULT, ir_data, 0);
        model_cnt = 4'd0;
        push(S_IDLE, ir_data, 0);
        push(S_IDLE, ir_data, 0);
        while (sb.size() > 0) begin
            applyStimulus(i == 6, (i == 0) || (i == 5), 1'b0, 1'b1);
            @(posedge clk); #1;
            e = sb.pop_front(); n_checks++;
            if ({observed(), instr_count} !== {e.vec, e.cnt}) begin
                n_fail++;
                $display("[TB] FAIL bad_op step %0d st=%0d: got %h/%0d expected %h/%0d", i, e.st, observed(), instr_count, e.vec, e.cnt);
            end
            i++;
        end
    endtask

    task automatic test_stop_midrun();
        exp_t e;
        int i = 0;
        ir_data = {5'b00100, 4'd3, 4'd1, 4'd2, 15'd0};
        push_instr(ir_data, 0);
        push(S_IDLE, ir_data, 0);
        while (sb.size() > 0) begin
            applyStimulus(1'b0, i <= 3, i == 4, 1'b1);
            @(posedge clk); #1;
            e = sb.pop_front(); n_checks++;
            if ({observed(), instr_count} !== {e.vec, e.cnt}) begin
                n_fail++;
                $display("[TB] FAIL stop_midrun step %0d st=%0d: got %h/%0d expected %h/%0d", i, e.st, observed(), instr_count, e.vec, e.cnt);
            end
            i++;
        end
    endtask

    task automatic test_clr_midrun();
        exp_t e;
        int i = 0;
        ir_data = {5'b00100, 4'd3, 4'd1, 4'd2, 15'd0};
        push(S_T0, ir_data, 0);
        push(S_T1, ir_data, 1);
        push(S_T2, ir_data, 0);
        push(S_T3, ir_data, 0);
        push(S_T4, ir_data, 0);
        model_cnt = 4'd0;
        push(S_IDLE, ir_data, 0);
        push(S_IDLE, ir_data, 0);
        while (sb.size() > 0) begin
            applyStimulus(i == 5, i <= 5, 1'b0, 1'b1);
            @(posedge clk); #1;
            e = sb.pop_front(); n_checks++;
            if ({observed(), instr_count} !== {e.vec, e.cnt}) begin
                n_fail++;
                $display("[TB] FAIL clr_midrun step %0d st=%0d: got %h/%0d expected %h/%0d", i, e.st, observed(), instr_count, e.vec, e.cnt);
            end
            i++;
        end
    endtask

    task automatic test_start_stop_same();
        exp_t e;
        int i = 0;
        repeat (3) push(S_IDLE, ir_data, 0);
        while (sb.size() > 0) begin
            applyStimulus(1'b0, i < 2, i < 2, 1'b1);
            @(posedge clk); #1;
            e = sb.pop_front(); n_checks++;
            if ({observed(), instr_count} !== {e.vec, e.cnt}) begin
                n_fail++;
                $display("[TB] FAIL start_stop_same step %0d st=%0d: got %h/%0d expected %h/%0d", i, e.st, observed(), instr_count, e.vec, e.cnt);
            end
            i++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int i = 0;
        ir_data = {5'b10000, 4'd7, 4'd9, 4'd0, 15'd0};
        push_instr(ir_data, 0);
        push_instr(ir_data, 0);
        push(S_IDLE, ir_data, 0);
        while (sb.size() > 0) begin
            applyStimulus(1'b0, i == 0, i == 9, 1'b1);
            @(posedge clk); #1;
            e = sb.pop_front(); n_checks++;
            if ({observed(), instr_count} !== {e.vec, e.cnt}) begin
                n_fail++;
                $display("[TB] FAIL back_to_back step %0d st=%0d: got %h/%0d expected %h/%0d", i, e.st, observed(), instr_count, e.vec, e.cnt);
            end
            i++;
        end
    endtask

    task automatic test_count_wrap();
        exp_t e;
        int i = 0;
        ir_data = {5'b10010, 4'd4, 4'd8, 4'd0, 15'd0};
        model_cnt = 4'd0;
        push(S_IDLE, ir_data, 0);
        repeat (16) push_instr(ir_data, 0);
        push(S_IDLE, ir_data, 0);
        while (sb.size() > 0) begin
            applyStimulus(i == 0, i == 1, i == 77, 1'b1);
            @(posedge clk); #1;
            e = sb.pop_front(); n_checks++;
            if ({observed(), instr_count} !== {e.vec, e.cnt}) begin
                n_fail++;
                $display("[TB] FAIL count_wrap step %0d st=%0d: got %h/%0d expected %h/%0d", i, e.st, observed(), instr_count, e.vec, e.cnt);
            end
            i++;
        end
        n_checks++;
        if (instr_count !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL wrap_value: got %0d expected 0", instr_count);
        end
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        ir_data = 32'h0;
        test_reset();
        test_rol();
        test_mem_wait(3);
        test_mem_wait(14);
        test_mul();
        test_back_to_back();
        test_stop_midrun();
        test_start_stop_same();
        test_clr_midrun();
        test_bad_op();
        test_wait_fault();
        test_count_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
